// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between the core store path and the
// data-memory write port, with store-to-load forwarding from the youngest
// matching entry.
// Optional feature macro: STORE_WRITE_BUFFER_COALESCE_EN
//   defined   -> a store to the youngest entry's address overwrites it in place
//   undefined -> every accepted store allocates a new entry
module store_write_buffer #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 64,
    parameter  int DATA_W = 64,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q;
    logic [PTR_W-1:0]   head_q, tail_q, young;
    logic [CNT_W-1:0]   cnt_q;
    logic               push, pop, coal;
    logic [DEPTH-1:0]   hit_v;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign count        = cnt_q;
    assign mem_wr_valid = !empty;
    assign mem_wr_addr  = ent_q[head_q].addr;
    assign mem_wr_data  = ent_q[head_q].data;
    assign pop          = !empty && mem_wr_ready;
    assign young        = tail_q - PTR_W'(1);

`ifdef STORE_WRITE_BUFFER_COALESCE_EN
    // Merge into the youngest entry unless that entry is the lone head leaving
    // this cycle; full implies count >= 2, so ready never depends on mem_wr_ready.
    assign coal     = st_valid && !empty && (st_addr == ent_q[young].addr) &&
                      !(pop && cnt_q == CNT_W'(1));
    assign st_ready = !full || coal;
`else
    assign coal     = 1'b0;
    assign st_ready = !full;
`endif

    assign push = st_valid && st_ready && !coal;

    // Per-slot match: slot is occupied when its age from head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign hit_v[g] = (CNT_W'(PTR_W'(g) - head_q) < cnt_q) &&
                          (ent_q[g].addr == ld_addr);
    end

    assign ld_hit = |hit_v;

    // Walk oldest to youngest so the last (youngest) match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        ld_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (hit_v[idx]) ld_data = ent_q[idx].data;
        end
    end

    // Queue state: entries, pointers and explicit occupancy count.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            ent_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                ent_q[tail_q] <= {st_addr, st_data};
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (coal) ent_q[young].data <= st_data;
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
